// File: rtl/uncache_store_buffer.sv
// uncache_store_buffer: in-order posted-write FIFO for uncached stores; loads issue only once drained (optional UCB_PERF_CNT_EN perf counters); ports: req_* from MEM, rsp_* to pipeline, bus_* to AXI bridge, buf_empty_o for fence drain
module uncache_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  input  logic          req_wr_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [1:0]    req_size_i,
  input  logic [3:0]    req_wstrb_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          req_ready_o,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          buf_empty_o,
  output logic          bus_req_o,
  output logic          bus_wr_o,
  output logic [1:0]    bus_size_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [3:0]    bus_wstrb_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_addr_ok_i,
  input  logic          bus_data_ok_i,
  input  logic [DW-1:0] bus_rdata_i
`ifdef UCB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_st_cnt_o,
  output logic [31:0]   perf_stall_cnt_o
`endif
);
  localparam int AIW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} state_e;
  state_e state_q;
  logic [AIW:0] wptr_q, rptr_q;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [1:0] size_mem_q [DEPTH];
  logic [3:0] strb_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic st_rsp_q, bus_req_q, bus_wr_q;
  logic [1:0] bus_size_q;
  logic [AW-1:0] bus_addr_q;
  logic [3:0] bus_wstrb_q;
  logic [DW-1:0] bus_wdata_q;
  logic full, empty, idle, st_acc, ld_acc, rd_done;
  logic [AIW-1:0] head;
  assign full = (wptr_q[AIW] != rptr_q[AIW]) && (wptr_q[AIW-1:0] == rptr_q[AIW-1:0]);
  assign empty = wptr_q == rptr_q;
  assign idle = state_q == IDLE;
  assign head = rptr_q[AIW-1:0];
  assign req_ready_o = req_wr_i ? !full : (empty && idle);
  assign st_acc = req_valid_i && req_wr_i && !full;
  assign ld_acc = req_valid_i && !req_wr_i && empty && idle;
  assign rd_done = (state_q == RD_DATA) && bus_data_ok_i;
  // load data is passed straight through on the data_ok cycle
  assign rsp_valid_o = st_rsp_q || rd_done;
  assign rsp_rdata_o = rd_done ? bus_rdata_i : '0;
  assign buf_empty_o = empty && idle;
  assign bus_req_o = bus_req_q;
  assign bus_wr_o = bus_wr_q;
  assign bus_size_o = bus_size_q;
  assign bus_addr_o = bus_addr_q;
  assign bus_wstrb_o = bus_wstrb_q;
  assign bus_wdata_o = bus_wdata_q;
  always_ff @(posedge clk) begin
    if (st_acc) begin
      addr_mem_q[wptr_q[AIW-1:0]] <= req_addr_i;
      size_mem_q[wptr_q[AIW-1:0]] <= req_size_i;
      strb_mem_q[wptr_q[AIW-1:0]] <= req_wstrb_i;
      data_mem_q[wptr_q[AIW-1:0]] <= req_wdata_i;
    end
  end
  // bus_* fields load only when leaving IDLE, so they hold steady until addr_ok
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      st_rsp_q <= 1'b0;
      bus_req_q <= 1'b0;
      bus_wr_q <= 1'b0;
      bus_size_q <= '0;
      bus_addr_q <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
    end else begin
      st_rsp_q <= st_acc;
      if (st_acc) wptr_q <= wptr_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (ld_acc) begin
            state_q <= RD_ADDR;
            bus_req_q <= 1'b1;
            bus_wr_q <= 1'b0;
            bus_size_q <= req_size_i;
            bus_addr_q <= req_addr_i;
            bus_wstrb_q <= '0;
            bus_wdata_q <= '0;
          end else if (!empty) begin
            state_q <= WR_ADDR;
            bus_req_q <= 1'b1;
            bus_wr_q <= 1'b1;
            bus_size_q <= size_mem_q[head];
            bus_addr_q <= addr_mem_q[head];
            bus_wstrb_q <= strb_mem_q[head];
            bus_wdata_q <= data_mem_q[head];
          end
        end
        WR_ADDR: if (bus_addr_ok_i) begin
          state_q <= WR_DATA;
          bus_req_q <= 1'b0;
        end
        WR_DATA: if (bus_data_ok_i) begin
          state_q <= IDLE;
          bus_wr_q <= 1'b0;
          rptr_q <= rptr_q + 1'b1;
        end
        RD_ADDR: if (bus_addr_ok_i) begin
          state_q <= RD_DATA;
          bus_req_q <= 1'b0;
        end
        RD_DATA: if (bus_data_ok_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef UCB_PERF_CNT_EN
  logic [31:0] perf_st_cnt_q, perf_stall_cnt_q;
  assign perf_st_cnt_o = perf_st_cnt_q;
  assign perf_stall_cnt_o = perf_stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_st_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_st_cnt_q <= perf_st_cnt_q + 32'(st_acc);
      perf_stall_cnt_q <= perf_stall_cnt_q + 32'(req_valid_i && !req_ready_o);
    end
  end
`endif
endmodule

// File: tb/tb_uncache_store_buffer.sv
// tb_uncache_store_buffer: directed-vector bench for uncache_store_buffer
module tb_uncache_store_buffer;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 0, req_wr = 0, req_ready, rsp_valid, buf_empty;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, bus_addr, bus_wdata, bus_rdata = 0;
  logic [1:0] req_size = 0, bus_size;
  logic [3:0] req_wstrb = 0, bus_wstrb;
  logic bus_req, bus_wr, bus_addr_ok = 0, bus_data_ok = 0;
`ifdef UCB_PERF_CNT_EN
  logic [31:0] perf_st_cnt, perf_stall_cnt;
`endif
  int vec_n = 0, err_n = 0, stall_n = 0;
  logic [31:0] wa[$], wd[$];
  uncache_store_buffer dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_wr_i(req_wr), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_wstrb_i(req_wstrb), .req_wdata_i(req_wdata), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .buf_empty_o(buf_empty),
    .bus_req_o(bus_req), .bus_wr_o(bus_wr), .bus_size_o(bus_size), .bus_addr_o(bus_addr),
    .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata), .bus_addr_ok_i(bus_addr_ok),
    .bus_data_ok_i(bus_data_ok), .bus_rdata_i(bus_rdata)
`ifdef UCB_PERF_CNT_EN
    , .perf_st_cnt_o(perf_st_cnt), .perf_stall_cnt_o(perf_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) stall_n = 0;
    else begin
      if (req_valid && !req_ready) stall_n++;
      if (bus_req && bus_wr && bus_addr_ok) begin
        wa.push_back(bus_addr);
        wd.push_back(bus_wdata);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    req_valid = 0;
    req_wr = 0;
    bus_addr_ok = 0;
    bus_data_ok = 0;
    tick();
    tick();
    rst = 0;
    wa.delete();
    wd.delete();
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1;
    req_wr = 1;
    req_addr = a;
    req_wdata = d;
    req_size = 2;
    req_wstrb = 4'hF;
  endtask
  task automatic wait_empty(input string tag);
    for (int i = 0; i < 60 && !buf_empty; i++) tick();
    chk(tag, {31'd0, buf_empty}, 1);
  endtask
  task automatic run_fill(input string p, input logic [31:0] base);
    wa.delete();
    wd.delete();
    bus_addr_ok = 0;
    bus_data_ok = 0;
    for (int i = 0; i < 4; i++) begin
      store(base + 32'(4 * i), base + 32'h100 + 32'(i));
      #1 chk({p, "_rdy"}, {31'd0, req_ready}, 1);
      tick();
      if (i == 0) chk({p, "_rsp"}, {31'd0, rsp_valid}, 1);
    end
    store(base + 32'd16, base + 32'h104);
    #1 chk({p, "_full"}, {31'd0, req_ready}, 0);
    tick();
    tick();
    chk({p, "_hold_req"}, {31'd0, bus_req}, 1);
    chk({p, "_hold_addr"}, bus_addr, base);
    bus_addr_ok = 1;
    tick();
    bus_addr_ok = 0;
    bus_data_ok = 1;
    #1 chk({p, "_pop_refuse"}, {31'd0, req_ready}, 0);
    tick();
    bus_data_ok = 0;
    #1 chk({p, "_after_pop"}, {31'd0, req_ready}, 1);
    tick();
    req_valid = 0;
    bus_addr_ok = 1;
    bus_data_ok = 1;
    wait_empty({p, "_drain"});
    bus_addr_ok = 0;
    bus_data_ok = 0;
    chk({p, "_nwr"}, 32'(wa.size()), 5);
    for (int i = 0; i < 5 && i < wa.size(); i++) begin
      chk({p, "_waddr"}, wa[i], base + 32'(4 * i));
      chk({p, "_wdata"}, wd[i], base + 32'h100 + 32'(i));
    end
  endtask
  initial begin
    do_reset();
    #1;
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_empty", {31'd0, buf_empty}, 1);
    chk("rst_busreq", {31'd0, bus_req}, 0);
    chk("rst_rsp", {31'd0, rsp_valid}, 0);
    // single store with an immediately-responding bus
    store(32'hBFAF_F000, 32'h1234_5678);
    bus_addr_ok = 1;
    bus_data_ok = 1;
    tick();
    req_valid = 0;
    #1 chk("s1_rsp", {31'd0, rsp_valid}, 1);
    chk("s1_noreq_yet", {31'd0, bus_req}, 0);
    tick();
    chk("s1_rsp_pulse", {31'd0, rsp_valid}, 0);
    chk("s1_req", {31'd0, bus_req}, 1);
    chk("s1_wr", {31'd0, bus_wr}, 1);
    chk("s1_addr", bus_addr, 32'hBFAF_F000);
    chk("s1_data", bus_wdata, 32'h1234_5678);
    chk("s1_strb", {28'd0, bus_wstrb}, 32'hF);
    chk("s1_size", {30'd0, bus_size}, 2);
    tick();
    chk("s1_reqdrop", {31'd0, bus_req}, 0);
    chk("s1_notempty", {31'd0, buf_empty}, 0);
    tick();
    chk("s1_empty", {31'd0, buf_empty}, 1);
    bus_addr_ok = 0;
    bus_data_ok = 0;
    // overflow with stalled bus, then pointer wrap on a second pass
    do_reset();
    run_fill("s2", 32'hBFAF_0000);
    chk("s2_stalls", 32'(stall_n), 4);
`ifdef UCB_PERF_CNT_EN
    chk("s6_st_cnt", perf_st_cnt, 5);
    chk("s6_stall_cnt", perf_stall_cnt, 32'(stall_n));
`endif
    run_fill("s4", 32'hBFAC_0000);
    // load behind pending stores
    do_reset();
    bus_rdata = 32'hDEAD_BEEF;
    store(32'hBFAF_1000, 32'hA1);
    tick();
    store(32'hBFAF_1004, 32'hA2);
    tick();
    req_wr = 0;
    req_addr = 32'hBFD0_0000;
    req_wstrb = 0;
    #1 chk("s3_stall", {31'd0, req_ready}, 0);
    bus_addr_ok = 1;
    bus_data_ok = 1;
    for (int i = 0; i < 40 && !req_ready; i++) tick();
    chk("s3_ready", {31'd0, req_ready}, 1);
    chk("s3_writes_done", 32'(wa.size()), 2);
    tick();
    req_valid = 0;
    bus_data_ok = 0;
    #1 chk("s3_rdreq", {31'd0, bus_req}, 1);
    chk("s3_rdwr", {31'd0, bus_wr}, 0);
    chk("s3_rdaddr", bus_addr, 32'hBFD0_0000);
    chk("s3_norsp", {31'd0, rsp_valid}, 0);
    tick();
    bus_data_ok = 1;
    #1 chk("s3_rsp", {31'd0, rsp_valid}, 1);
    chk("s3_rdata", rsp_rdata, 32'hDEAD_BEEF);
    tick();
    bus_addr_ok = 0;
    bus_data_ok = 0;
    #1 chk("s3_empty", {31'd0, buf_empty}, 1);
    chk("s3_rsp_end", {31'd0, rsp_valid}, 0);
    // reset in WR_DATA with three entries queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      store(32'hBFAE_0000 + 32'(4 * i), 32'h55 + 32'(i));
      tick();
    end
    req_valid = 0;
    bus_addr_ok = 1;
    tick();
    bus_addr_ok = 0;
    chk("s5_wrdata", {31'd0, bus_req}, 0);
    chk("s5_busy", {31'd0, buf_empty}, 0);
    rst = 1;
    tick();
    chk("s5_req", {31'd0, bus_req}, 0);
    chk("s5_empty", {31'd0, buf_empty}, 1);
    chk("s5_ready", {31'd0, req_ready}, 1);
    rst = 0;
    wa.delete();
    wd.delete();
    bus_addr_ok = 1;
    bus_data_ok = 1;
    repeat (12) tick();
    chk("s5_no_stale", 32'(wa.size()), 0);
    chk("s5_still_empty", {31'd0, buf_empty}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule
